// File: rtl/spi_mnrch_multi.sv
// SPI monarch, mode 3, with parametrised word width, SCLK divide and serf-select count.
// Define SPI_MNRCH_LSB_FIRST_EN to shift LSB first on both MOSI and MISO (default: MSB first).
module spi_mnrch_multi #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DIV_LOG2 = 4,
  parameter int unsigned NUM_SS   = 1,
  localparam int unsigned SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [DATA_W-1:0] wt_data,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned BC_W = $clog2(DATA_W + 1);
  localparam logic [DIV_LOG2-1:0] LD =
    DIV_LOG2'((1 << (DIV_LOG2 - 1)) + (1 << (DIV_LOG2 - 2)) - 1);
  localparam logic [DIV_LOG2-1:0] SAMP = DIV_LOG2'((1 << (DIV_LOG2 - 1)) + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    BACKPORCH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   shft_q, shft_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
  logic [DATA_W-1:0]   shft_in;

`ifdef SPI_MNRCH_LSB_FIRST_EN
  assign shft_in = {MISO, shft_q[DATA_W-1:1]};
  assign MOSI    = shft_q[0];
`else
  assign shft_in = {shft_q[DATA_W-2:0], MISO};
  assign MOSI    = shft_q[DATA_W-1];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shft_d    = shft_q;
    bit_cnt_d = bit_cnt_q;
    sel_d     = sel_q;
    done_d    = done_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = LD;
        if (wrt) begin
          shft_d    = wt_data;
          sel_d     = ss_sel;
          bit_cnt_d = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SAMP) begin
          shft_d    = shft_in;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (bit_cnt_q == BC_W'(DATA_W)) state_d = BACKPORCH;
      end
      BACKPORCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = LD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Selects are registered from the next-state decode so the pins never glitch.
  always_comb begin
    ss_n_d = '1;
    if (state_d != IDLE) begin
      for (int unsigned i = 0; i < NUM_SS; i++) begin
        if (i == 32'(sel_d)) ss_n_d[i] = 1'b0;
      end
    end
  end

  // Divider resets to the idle load value so SCLK comes out of reset high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= LD;
      shft_q    <= '0;
      bit_cnt_q <= '0;
      sel_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ss_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shft_q    <= shft_d;
      bit_cnt_q <= bit_cnt_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ss_n_q    <= ss_n_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = cnt_q[DIV_LOG2-1];
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = shft_q;

endmodule

// File: tb/tb_spi_mnrch_multi.sv
// Directed bench for spi_mnrch_multi: default, 4-select and 8-bit/divide-by-8 instances.
module tb_spi_mnrch_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: DATA_W=16, DIV_LOG2=4, NUM_SS=1
  logic        wrt16 = 1'b0, sel16 = 1'b0, loop16 = 1'b1;
  logic [15:0] wt16 = '0, rd16;
  logic [0:0]  ss16;
  logic        sclk16, mosi16, miso16, busy16, done16;

  // Instance B: NUM_SS=4, loopback
  logic        wrt4 = 1'b0;
  logic [1:0]  sel4 = '0;
  logic [15:0] wt4 = '0, rd4;
  logic [3:0]  ss4;
  logic        sclk4, mosi4, busy4, done4;

  // Instance C: DATA_W=8, DIV_LOG2=3, loopback
  logic        wrt8 = 1'b0, sel8 = 1'b0;
  logic [7:0]  wt8 = '0, rd8;
  logic [0:0]  ss8;
  logic        sclk8, mosi8, busy8, done8;

  spi_mnrch_multi #(.DATA_W(16), .DIV_LOG2(4), .NUM_SS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wrt(wrt16), .ss_sel(sel16), .wt_data(wt16), .MISO(miso16),
    .SS_n(ss16), .SCLK(sclk16), .MOSI(mosi16), .busy(busy16), .done(done16), .rd_data(rd16));

  spi_mnrch_multi #(.DATA_W(16), .DIV_LOG2(4), .NUM_SS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .wrt(wrt4), .ss_sel(sel4), .wt_data(wt4), .MISO(mosi4),
    .SS_n(ss4), .SCLK(sclk4), .MOSI(mosi4), .busy(busy4), .done(done4), .rd_data(rd4));

  spi_mnrch_multi #(.DATA_W(8), .DIV_LOG2(3), .NUM_SS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wrt(wrt8), .ss_sel(sel8), .wt_data(wt8), .MISO(mosi8),
    .SS_n(ss8), .SCLK(sclk8), .MOSI(mosi8), .busy(busy8), .done(done8), .rd_data(rd8));

  // Serf model for instance A: launches a bit on each SCLK fall, captures MOSI on each rise.
  logic [15:0] serf_word = '0;
  logic [15:0] serf_rx = '0;
  int          nf = 0;
  int          falls = 0;
  logic        serf_miso;

  always @(negedge sclk16 or posedge ss16[0]) begin
    if (ss16[0]) nf <= 0;
    else         nf <= nf + 1;
  end
  always @(negedge sclk16) falls <= falls + 1;
  always @(posedge sclk16) if (!ss16[0]) serf_rx <= {serf_rx[14:0], mosi16};

  always_comb begin
    serf_miso = 1'b0;
    if (nf >= 1 && nf <= 16) serf_miso = serf_word[16 - nf];
  end
  assign miso16 = loop16 ? mosi16 : serf_miso;

  task automatic start16(input logic [15:0] d, input logic s);
    @(posedge clk); #1;
    wt16 = d; sel16 = s; wrt16 = 1'b1;
    @(posedge clk); #1;
    wrt16 = 1'b0;
  endtask

  task automatic wait16(output int n);
    n = 0;
    while (done16 !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ss16, sclk16, mosi16, busy16, done16, rd16} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_a: ss=%b sclk=%b mosi=%b busy=%b done=%b rd=%h, want 1 1 0 0 0 0000",
               ss16, sclk16, mosi16, busy16, done16, rd16);
    end
    n_checks++;
    if ({ss4, sclk4, busy4, done4, rd4} !== {4'b1111, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_b: ss=%b sclk=%b busy=%b done=%b rd=%h, want 1111 1 0 0 0000",
               ss4, sclk4, busy4, done4, rd4);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_loopback;
    int n, f0;
    loop16 = 1'b1;
    f0 = falls;
    start16(16'hA5C3, 1'b0);
    n_checks++;
    if (ss16 !== 1'b0 || busy16 !== 1'b1) begin
      n_fail++;
      $display("FAIL loop_start: ss=%b busy=%b, want 0 1", ss16, busy16);
    end
    wait16(n);
    n_checks++;
    if (n !== 261) begin n_fail++; $display("FAIL loop_latency: got %0d clk, want 261", n); end
    n_checks++;
    if (falls - f0 !== 16) begin n_fail++; $display("FAIL loop_falls: got %0d, want 16", falls - f0); end
    n_checks++;
    if (rd16 !== 16'hA5C3) begin n_fail++; $display("FAIL loop_rd: got %h, want a5c3", rd16); end
    n_checks++;
    if (serf_rx !== 16'hA5C3) begin n_fail++; $display("FAIL loop_mosi: serf saw %h, want a5c3", serf_rx); end
    n_checks++;
    if (ss16 !== 1'b1 || busy16 !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_end: ss=%b busy=%b, want 1 0", ss16, busy16);
    end
  endtask

  task automatic test_serf_data;
    int n;
    loop16 = 1'b0;
    serf_word = 16'h1234;
    start16(16'hFFFF, 1'b0);
    wait16(n);
    n_checks++;
    if (n !== 261) begin n_fail++; $display("FAIL serf_latency: got %0d clk, want 261", n); end
    n_checks++;
    if (rd16 !== 16'h1234) begin n_fail++; $display("FAIL serf_rd: got %h, want 1234", rd16); end
    n_checks++;
    if (serf_rx !== 16'hFFFF) begin n_fail++; $display("FAIL serf_mosi: serf saw %h, want ffff", serf_rx); end
    loop16 = 1'b1;
  endtask

  task automatic test_wrt_with_done;
    int n;
    n_checks++;
    if (done16 !== 1'b1) begin n_fail++; $display("FAIL done_held: got %b, want 1", done16); end
    start16(16'h3C96, 1'b0);
    n_checks++;
    if (done16 !== 1'b0 || busy16 !== 1'b1) begin
      n_fail++;
      $display("FAIL done_clear: done=%b busy=%b, want 0 1", done16, busy16);
    end
    wait16(n);
    n_checks++;
    if (n !== 261 || rd16 !== 16'h3C96) begin
      n_fail++;
      $display("FAIL done_rerun: n=%0d rd=%h, want 261 3c96", n, rd16);
    end
  endtask

  task automatic test_bad_sel;
    int n;
    start16(16'h0F0F, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (ss16 !== 1'b1 || busy16 !== 1'b1) begin
      n_fail++;
      $display("FAIL badsel_ss: ss=%b busy=%b, want 1 1", ss16, busy16);
    end
    wait16(n);
    n_checks++;
    if (n !== 221 || rd16 !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL badsel_done: n=%0d rd=%h, want 221 0f0f", n, rd16);
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    @(posedge clk); #1;
    wt4 = 16'hC0DE; sel4 = 2'd2; wrt4 = 1'b1;
    @(posedge clk); #1;
    wrt4 = 1'b0;
    n_checks++;
    if (ss4 !== 4'b1011) begin n_fail++; $display("FAIL sel2_ss: got %b, want 1011", ss4); end
    n = 0;
    while (done4 !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
      if (n == 50) begin wrt4 = 1'b1; wt4 = 16'h1111; sel4 = 2'd1; end
      if (n == 51) wrt4 = 1'b0;
      if (n == 52) begin
        n_checks++;
        if (ss4 !== 4'b1011 || busy4 !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_wrt_ss: ss=%b busy=%b, want 1011 1", ss4, busy4);
        end
      end
    end
    n_checks++;
    if (n !== 261) begin n_fail++; $display("FAIL busy_latency: got %0d clk, want 261", n); end
    n_checks++;
    if (rd4 !== 16'hC0DE || ss4 !== 4'b1111) begin
      n_fail++;
      $display("FAIL busy_rd: rd=%h ss=%b, want c0de 1111", rd4, ss4);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    start16(16'hBEEF, 1'b0);
    repeat (99) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ss16, sclk16, busy16, done16, rd16} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL midrst_now: ss=%b sclk=%b busy=%b done=%b rd=%h, want 1 1 0 0 0000",
               ss16, sclk16, busy16, done16, rd16);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    n_checks++;
    if (done16 !== 1'b0 || ss16 !== 1'b1 || sclk16 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_quiet: done=%b ss=%b sclk=%b, want 0 1 1", done16, ss16, sclk16);
    end
    start16(16'h5A0F, 1'b0);
    wait16(n);
    n_checks++;
    if (n !== 261 || rd16 !== 16'h5A0F) begin
      n_fail++;
      $display("FAIL midrst_rerun: n=%0d rd=%h, want 261 5a0f", n, rd16);
    end
  endtask

  task automatic test_narrow;
    int n;
    logic exp_first;
`ifdef SPI_MNRCH_LSB_FIRST_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    @(posedge clk); #1;
    wt8 = 8'h01; sel8 = 1'b0; wrt8 = 1'b1;
    @(posedge clk); #1;
    wrt8 = 1'b0;
    n_checks++;
    if (mosi8 !== exp_first || ss8 !== 1'b0) begin
      n_fail++;
      $display("FAIL narrow_first: mosi=%b ss=%b, want %b 0", mosi8, ss8, exp_first);
    end
    n = 0;
    while (done8 !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (n !== 59 || rd8 !== 8'h01) begin
      n_fail++;
      $display("FAIL narrow_done: n=%0d rd=%h, want 59 01", n, rd8);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_serf_data();
    test_wrt_with_done();
    test_bad_sel();
    test_busy_ignore();
    test_reset_mid();
    test_narrow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
